// File: rtl/packet_hash_stripper_pkg.sv
// Shared constants, state encoding and strobe decode for the packet hash stripper.
package packet_hash_stripper_pkg;

  localparam int          HASH_BYTES = 16;
  localparam logic [31:0] ALL_VALID  = 32'hffffffff;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Byte count of a lane-31-downward contiguous strobe; same decode as the cutter.
  function automatic logic [5:0] strb_bytes(input logic [31:0] strb);
    logic [5:0] cnt;
    cnt = '0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + 6'(strb[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/packet_hash_stripper_hash_trailer_extract.sv
// Combinational trailer extraction: pulls the 128-bit hash out of the final
// held/last word pair and computes the strobe of the word that ends the packet.
module hash_trailer_extract
  import packet_hash_stripper_pkg::*;
(
  input  logic [255:0] held_word,
  input  logic [255:0] last_word,
  input  logic [5:0]   n,
  output logic [127:0] hash,
  output logic [31:0]  out_strb
);

  logic [511:0] shifted;
  logic [8:0]   shift_bits;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    shift_bits = {3'b000, 6'd32 - n} << 3;
    shifted    = {held_word, last_word} >> shift_bits;
    hash       = shifted[127:0];
    // n>16: the trailer sits wholly in the last word; else it ends the packet inside the held word.
    if (n > 6'(HASH_BYTES)) out_strb = ALL_VALID << (6'd48 - n);
    else                    out_strb = ALL_VALID << (6'd16 - n);
  end

endmodule

// File: rtl/packet_hash_stripper.sv
// Strips the 128-bit hash trailer from cut packets and reports it on a sideband.
// Optional counters: define PKT_HASH_STRIP_CNT_EN to add stripped_pkt_cnt / err_pkt_cnt.
module packet_hash_stripper
  import packet_hash_stripper_pkg::*;
#(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int HASH_WIDTH           = 128
) (
  input  logic                              axi_aclk,
  input  logic                              axi_resetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  input  logic                              strip_en,
  output logic [HASH_WIDTH-1:0]             hash_out,
  output logic                              hash_valid,
  output logic                              hash_err
`ifdef PKT_HASH_STRIP_CNT_EN
  ,
  output logic [31:0]                       stripped_pkt_cnt,
  output logic [31:0]                       err_pkt_cnt
`endif
);

  state_t                            state;
  logic [C_S_AXIS_DATA_WIDTH-1:0]    hold_data;
  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  hold_strb;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]   pkt_user;
  logic                              pkt_strip;

  logic [5:0]                        n;
  logic                              long_trailer;
  logic                              eff_strip;
  logic                              s_fire;
  logic                              trim_held;
  logic                              load_word;
  logic [C_S_AXIS_DATA_WIDTH-1:0]    held_word;
  logic [HASH_WIDTH-1:0]             x_hash;
  logic [C_M_AXIS_DATA_WIDTH/8-1:0]  x_strb;
  logic [15:0]                       trimmed_len;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]   first_user;

  assign n            = strb_bytes(s_axis_tstrb);
  assign long_trailer = (n > 6'(HASH_BYTES));
  assign held_word    = (state == HOLD) ? hold_data : '0;
  // Strip setting is taken live on a first word and from the latched copy afterwards.
  assign eff_strip    = (state == EMPTY) ? strip_en : pkt_strip;

  hash_trailer_extract u_extract (
    .held_word (held_word),
    .last_word (s_axis_tdata),
    .n         (n),
    .hash      (x_hash),
    .out_strb  (x_strb)
  );

  assign s_axis_tready = (state == EMPTY) || ((state == HOLD) && m_axis_tready);
  assign m_axis_tvalid = (state == DRAIN) || ((state == HOLD) && s_axis_tvalid);
  assign s_fire        = s_axis_tvalid && s_axis_tready;

  // The held word becomes the packet end when the incoming last word is pure trailer.
  assign trim_held     = (state == HOLD) && s_axis_tlast && pkt_strip && !long_trailer;
  assign load_word     = s_fire && !trim_held;

  assign m_axis_tdata  = hold_data;
  assign m_axis_tstrb  = trim_held ? x_strb : hold_strb;
  assign m_axis_tlast  = (state == DRAIN) || trim_held;
  assign m_axis_tuser  = pkt_user;

  assign trimmed_len = (s_axis_tuser[15:0] > 16'(HASH_BYTES)) ?
                       s_axis_tuser[15:0] - 16'(HASH_BYTES) : 16'd0;
  assign first_user  = (strip_en && (!s_axis_tlast || long_trailer)) ?
                       {s_axis_tuser[C_S_AXIS_TUSER_WIDTH-1:16], trimmed_len} : s_axis_tuser;

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state      <= EMPTY;
      pkt_strip  <= 1'b0;
      hash_out   <= '0;
      hash_valid <= 1'b0;
      hash_err   <= 1'b0;
    end else begin
      hash_valid <= 1'b0;
      hash_err   <= 1'b0;
      unique case (state)
        EMPTY: begin
          if (s_axis_tvalid) begin
            // A too-short packet is forwarded untouched, so it counts as not stripped.
            pkt_strip <= strip_en && (!s_axis_tlast || long_trailer);
            if (s_axis_tlast) begin
              state <= DRAIN;
              if (strip_en && long_trailer) begin
                hash_valid <= 1'b1;
                hash_out   <= x_hash;
              end
              if (strip_en && !long_trailer) hash_err <= 1'b1;
            end else begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (s_fire && s_axis_tlast) begin
            if (pkt_strip) begin
              hash_valid <= 1'b1;
              hash_out   <= x_hash;
            end
            state <= (!pkt_strip || long_trailer) ? DRAIN : EMPTY;
          end
        end
        DRAIN: begin
          if (m_axis_tready) state <= EMPTY;
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // NOTE: datapath registers carry no reset; m_axis_tvalid gates them until a word is loaded.
  always_ff @(posedge axi_aclk) begin
    if (load_word) begin
      hold_data <= s_axis_tdata;
      hold_strb <= (s_axis_tlast && eff_strip && long_trailer) ?
                   (s_axis_tstrb << HASH_BYTES) : s_axis_tstrb;
    end
    if (s_fire && (state == EMPTY)) pkt_user <= first_user;
  end

`ifdef PKT_HASH_STRIP_CNT_EN
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      stripped_pkt_cnt <= '0;
      err_pkt_cnt      <= '0;
    end else begin
      if (hash_valid) stripped_pkt_cnt <= stripped_pkt_cnt + 32'd1;
      if (hash_err)   err_pkt_cnt      <= err_pkt_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_packet_hash_stripper.sv
// Scoreboard bench for packet_hash_stripper: packet-level byte model, random backpressure.
module tb_packet_hash_stripper;
  import packet_hash_stripper_pkg::*;

  logic         axi_aclk = 1'b0;
  logic         axi_resetn;
  logic [255:0] s_axis_tdata;
  logic [31:0]  s_axis_tstrb;
  logic [127:0] s_axis_tuser;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         s_axis_tlast;
  logic [255:0] m_axis_tdata;
  logic [31:0]  m_axis_tstrb;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;
  logic         strip_en;
  logic [127:0] hash_out;
  logic         hash_valid;
  logic         hash_err;
`ifdef PKT_HASH_STRIP_CNT_EN
  logic [31:0]  stripped_pkt_cnt;
  logic [31:0]  err_pkt_cnt;
`endif

  always #5 axi_aclk = ~axi_aclk;

  packet_hash_stripper dut (
    .axi_aclk      (axi_aclk),
    .axi_resetn    (axi_resetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tstrb  (s_axis_tstrb),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .strip_en      (strip_en),
    .hash_out      (hash_out),
    .hash_valid    (hash_valid),
    .hash_err      (hash_err)
`ifdef PKT_HASH_STRIP_CNT_EN
    ,
    .stripped_pkt_cnt (stripped_pkt_cnt),
    .err_pkt_cnt      (err_pkt_cnt)
`endif
  );

  typedef struct packed {
    logic [255:0] data;
    logic [31:0]  strb;
    logic [127:0] user;
    logic         last;
  } beat_t;

  beat_t        exp_q[$];
  logic [127:0] hash_q[$];
  int           err_pending = 0;
  int           good_total  = 0;
  int           err_total   = 0;
  int           tests       = 0;
  int           fails       = 0;
  bit           mon_en      = 1'b0;
  int           ready_mode  = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Builds a k-word packet whose last word holds n bytes, queues the expected result, drives it.
  task automatic send_pkt(input int k, input int n, input bit strip, input bit toggle);
    logic [255:0] w [];
    logic [127:0] user;
    logic [127:0] user_mod;
    logic [127:0] hash;
    beat_t        b;
    int           len, len_out, nout, j, waited;
    bit           good;
    w    = new[k];
    for (int i = 0; i < k; i++) w[i] = rand256();
    len  = 32 * (k - 1) + n;
    user = {rand256() >> 144, 16'(len)};
    good = strip && (len > 16);
    if (good) begin
      len_out  = len - 16;
      nout     = (len_out + 31) / 32;
      user_mod = {user[127:16], 16'(len_out)};
      for (int i = 0; i < nout; i++) begin
        b.data = w[i];
        b.strb = (i == nout - 1) ? (ALL_VALID << (32 * nout - len_out)) : ALL_VALID;
        b.user = user_mod;
        b.last = (i == nout - 1);
        exp_q.push_back(b);
      end
      for (int i = 0; i < 16; i++) begin
        j = len - 16 + i;
        hash[8*(15-i) +: 8] = w[j/32][8*(31-(j%32)) +: 8];
      end
      hash_q.push_back(hash);
      good_total++;
    end else begin
      for (int i = 0; i < k; i++) begin
        b.data = w[i];
        b.strb = (i == k - 1) ? (ALL_VALID << (32 - n)) : ALL_VALID;
        b.user = user;
        b.last = (i == k - 1);
        exp_q.push_back(b);
      end
      if (strip) begin
        err_pending++;
        err_total++;
      end
    end
    for (int i = 0; i < k; i++) begin
      @(negedge axi_aclk);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = w[i];
      s_axis_tstrb  = (i == k - 1) ? (ALL_VALID << (32 - n)) : ALL_VALID;
      s_axis_tlast  = (i == k - 1);
      s_axis_tuser  = user;
      strip_en      = (i == 0) ? strip : (toggle ? 1'($urandom_range(0, 1)) : strip);
      #1;
      waited = 0;
      while (!s_axis_tready && waited < 200) begin
        @(negedge axi_aclk);
        #1;
        waited++;
      end
      if (!s_axis_tready) check("s_handshake_timeout", 1'b0, 1'b1);
      @(posedge axi_aclk);
    end
  endtask

  always @(negedge axi_aclk) begin
    case (ready_mode)
      0:       m_axis_tready = 1'b0;
      1:       m_axis_tready = 1'b1;
      default: m_axis_tready = 1'($urandom_range(0, 1));
    endcase
  end

  initial begin : monitor
    bit    stall_prev;
    beat_t e;
    stall_prev = 1'b0;
    forever begin
      @(negedge axi_aclk);
      #1;
      if (mon_en) begin
        if (hash_valid) begin
          if (hash_q.size() == 0) check("hash_valid_unexpected", 1'b1, 1'b0);
          else                    check("hash_out", hash_out, hash_q.pop_front());
        end
        if (hash_err) begin
          check("hash_err_expected", err_pending > 0, 1'b1);
          if (err_pending > 0) err_pending--;
        end
        if (stall_prev) check("tvalid_held", m_axis_tvalid, 1'b1);
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            check("out_unexpected", 1'b1, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check("tdata", m_axis_tdata, e.data);
            check("tstrb", m_axis_tstrb, e.strb);
            check("tuser", m_axis_tuser, e.user);
            check("tlast", m_axis_tlast, e.last);
          end
        end
        stall_prev = m_axis_tvalid && !m_axis_tready;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int waited;
    axi_resetn    = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tstrb  = '0;
    s_axis_tuser  = '0;
    s_axis_tlast  = 1'b0;
    strip_en      = 1'b0;
    repeat (3) @(posedge axi_aclk);
    #1;
    check("rst_m_tvalid", m_axis_tvalid, 1'b0);
    check("rst_s_tready", s_axis_tready, 1'b1);
    check("rst_hash_valid", hash_valid, 1'b0);
    check("rst_hash_err", hash_err, 1'b0);
    check("rst_hash_out", hash_out, 128'd0);
    @(negedge axi_aclk);
    axi_resetn = 1'b1;

    // Get into HOLD with the output stalled, then reset mid-packet.
    @(negedge axi_aclk);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = rand256();
    s_axis_tstrb  = ALL_VALID;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 128'd96;
    strip_en      = 1'b1;
    @(posedge axi_aclk);
    @(negedge axi_aclk);
    s_axis_tdata = rand256();
    #1;
    check("hold_m_tvalid", m_axis_tvalid, 1'b1);
    check("hold_s_tready", s_axis_tready, 1'b0);
    axi_resetn = 1'b0;
    #1;
    check("midrst_m_tvalid", m_axis_tvalid, 1'b0);
    check("midrst_s_tready", s_axis_tready, 1'b1);
    s_axis_tvalid = 1'b0;
    @(negedge axi_aclk);
    axi_resetn = 1'b1;

    mon_en     = 1'b1;
    ready_mode = 1;
    send_pkt(1, 24, 1'b1, 1'b0);
    send_pkt(2, 16, 1'b1, 1'b0);
    send_pkt(2, 8,  1'b1, 1'b0);
    send_pkt(1, 12, 1'b1, 1'b0);
    send_pkt(1, 16, 1'b1, 1'b0);
    send_pkt(3, 32, 1'b0, 1'b0);
    send_pkt(1, 32, 1'b1, 1'b0);
    send_pkt(2, 1,  1'b1, 1'b0);

    ready_mode = 2;
    for (int p = 0; p < 6; p++) send_pkt(64, $urandom_range(1, 32), 1'(p % 2 == 0), 1'b1);
    for (int p = 0; p < 20; p++)
      send_pkt($urandom_range(1, 4), $urandom_range(1, 32), 1'($urandom_range(0, 1)), 1'b1);

    @(negedge axi_aclk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    waited = 0;
    while ((exp_q.size() != 0 || hash_q.size() != 0 || err_pending != 0) && waited < 2000) begin
      @(negedge axi_aclk);
      waited++;
    end
    repeat (4) @(negedge axi_aclk);
    check("exp_q_drained", exp_q.size(), 0);
    check("hash_q_drained", hash_q.size(), 0);
    check("err_all_seen", err_pending, 0);
    check("idle_m_tvalid", m_axis_tvalid, 1'b0);
`ifdef PKT_HASH_STRIP_CNT_EN
    check("stripped_pkt_cnt", stripped_pkt_cnt, good_total);
    check("err_pkt_cnt", err_pkt_cnt, err_total);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/packet_hash_stripper.md
Name: packet_hash_stripper

Overview:
- Host-side counterpart of the monitor's packet cutter.
- Accepts cut packets on a 256-bit AXI4-Stream whose final 16 valid bytes are the 128-bit hash trailer.
- Removes the trailer, corrects the last-word tstrb and the tuser length field, and presents the extracted hash on a sideband.
- Uses a one-word holding buffer because the trailer may span two bus words.

Parameters:
- C_M_AXIS_DATA_WIDTH, 256, master data width (fixed at 256; 32 byte lanes).
- C_S_AXIS_DATA_WIDTH, 256, slave data width (must equal master).
- C_M_AXIS_TUSER_WIDTH, 128, master tuser width.
- C_S_AXIS_TUSER_WIDTH, 128, slave tuser width; bits [15:0] carry the packet byte length.
- HASH_WIDTH, 128, trailer width in bits (HASH_BYTES = 16).

Ports:
- axi_aclk  in  1  sole clock
- axi_resetn  in  1  asynchronous, active-low reset
- s_axis_tdata  in  256  input data
- s_axis_tstrb  in  32  byte valid; contiguous from lane 31 downward
- s_axis_tuser  in  128  metadata; [15:0] = byte length
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  end of packet
- m_axis_tdata  out  256  output data
- m_axis_tstrb  out  32  output byte valid
- m_axis_tuser  out  128  output metadata
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  end of packet
- strip_en  in  1  enable trailer stripping; sampled on the first word of each packet
- hash_out  out  128  last extracted hash; held until the next update
- hash_valid  out  1  one-cycle pulse when hash_out updates
- hash_err  out  1  one-cycle pulse on a packet too short to carry a trailer

Behaviour:
- Reset (asynchronous, active-low):
  - state=EMPTY; hold word discarded.
  - m_axis_tvalid=0, hash_valid=0, hash_err=0, hash_out=0.
  - A reset mid-packet drops that packet; the next accepted word is treated as a first word.
- States:
  - EMPTY: no word held.
  - HOLD: one non-final word held.
  - DRAIN: a tlast word is held.
- Handshake and outputs:
  - s_axis_tready = EMPTY | (HOLD & m_axis_tready); it is 0 in DRAIN.
  - m_axis_tvalid = DRAIN | (HOLD & s_axis_tvalid); it never depends on m_axis_tready.
  - m_axis_tdata and m_axis_tuser come from the hold register or from the HOLD-case modifications below.
- First-word capture: on the first word of a packet, latch strip_en and tuser. When stripping, output tuser = latched tuser with [15:0] reduced by 16 (saturating at 0); otherwise tuser passes unchanged. Every output word carries this tuser.
- Let n = popcount(s_axis_tstrb) of the incoming last word. Trailer extraction: hash = ({held_word, last_word} >> ((32-n)*8))[127:0]. held_word is zero in EMPTY.
- Transitions:
  - EMPTY, non-last accepted -> HOLD.
  - EMPTY, last accepted, n>16 and stripping -> DRAIN with tstrb<<16; hash_valid pulses.
  - EMPTY, last accepted, n<=16 or not stripping -> DRAIN unmodified. hash_err pulses if stripping with n<=16.
  - HOLD, non-last handshake: emit the held word, load the new word, stay in HOLD.
  - HOLD, last handshake, n>16: emit the held word with tlast=0; load the last word with tstrb<<16 -> DRAIN.
  - HOLD, last handshake, n=16: emit the held word with tlast=1 and full tstrb; drop the last word -> EMPTY.
  - HOLD, last handshake, n<16: emit the held word with tlast=1 and tstrb=32'hffffffff<<(16-n); drop the last word -> EMPTY.
  - HOLD, not stripping: the last word is loaded unmodified -> DRAIN.
  - DRAIN: on m_axis_tready, emit with tlast=1 -> EMPTY.
- hash_valid pulses the cycle the input last word is accepted in a good stripping case; hash_out is registered at the same edge.
- A change on strip_en mid-packet is ignored.
- Throughput: 1 word/cycle, except one bubble cycle per packet when the DRAIN state is used. Latency is one input word.

Optional Feature:
- Macro: PKT_HASH_STRIP_CNT_EN.
- When defined: adds outputs stripped_pkt_cnt[31:0] and err_pkt_cnt[31:0].
  - stripped_pkt_cnt increments on each hash_valid pulse.
  - err_pkt_cnt increments on each hash_err pulse.
  - Both counters wrap at 2^32 and are cleared by reset.
- When undefined: the ports and counter logic are absent.

Decomposition:
- Shared package: HASH_BYTES=16, ALL_VALID=32'hffffffff, state encodings (EMPTY/HOLD/DRAIN), and a popcount/strobe-to-bytes function shared with the cutter's strobe decode.
- One sub-module: hash_trailer_extract. It is combinational: it takes held_word, last_word and n, and returns hash and the output tstrb.

Test Plan:
- Single-word packet, strip_en=1, tstrb=32'hffffff00 (24 bytes), low 16 bytes = H → output 8 bytes (tstrb ff000000), tlast=1, tuser[15:0] 24->8, hash_out=H, one hash_valid pulse.
- 2-word packet, last word tstrb=32'hffff0000 (n=16) → one output word, full strobe, tlast=1; last word dropped; hash_out = last word [255:128].
- 2-word packet, last tstrb=32'hff000000 (n=8) → one output word, tstrb=32'hffffff00, tlast=1; hash = {held[63:0], last[255:192]}.
- Single-word packet with tstrb=32'hfff00000 (n=12), strip_en=1 → passed through unmodified, hash_err pulse, no hash_valid.
- Random m_axis_tready backpressure with back-to-back 64-word packets, strip_en toggled mid-packet → data integrity, tvalid never drops before its handshake, strip setting follows the first word of each packet.
- Assert axi_resetn low while in HOLD → m_axis_tvalid=0 immediately; the next packet is processed cleanly.
